// File: rtl/box_pkg.sv
// Shared types and helpers for the frame-synchronous box table.
// Coordinate fields are 12 bits wide, the declared width of H_ACT/V_ACT.
package box_pkg;

    localparam int AGE_W = 8;
    localparam int CW    = 12;

    typedef struct packed {
        logic [CW-1:0] x0;
        logic [CW-1:0] y0;
        logic [CW-1:0] x1;
        logic [CW-1:0] y1;
        logic [23:0]   color;
    } box_t;

    // Clamp each bound to the active area, then order each pair so x0<=x1, y0<=y1.
    function automatic box_t box_sanitize(input box_t b, input logic [CW-1:0] x_max,
                                          input logic [CW-1:0] y_max);
        box_t          o;
        logic [CW-1:0] xa, xb, ya, yb;
        xa = (b.x0 > x_max) ? x_max : b.x0;
        xb = (b.x1 > x_max) ? x_max : b.x1;
        ya = (b.y0 > y_max) ? y_max : b.y0;
        yb = (b.y1 > y_max) ? y_max : b.y1;
        o.x0    = (xa > xb) ? xb : xa;
        o.x1    = (xa > xb) ? xa : xb;
        o.y0    = (ya > yb) ? yb : ya;
        o.y1    = (ya > yb) ? ya : yb;
        o.color = b.color;
        return o;
    endfunction

endpackage

// File: rtl/box_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from rr, wrapping.
// rr moves past the winner after every grant; stall forces all grants low.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic         stall,
    output logic [N-1:0] gnt
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic [RW-1:0] rr_q, rr_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt   = '0;
        rr_d  = rr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(rr_q) + i) % N;
            if (!stall && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                rr_d     = RW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/box_scheduler.sv
// Box table: requesters write a shadow table through a round-robin arbiter;
// the shadow is aged and copied to the live outputs once per frame start.
module box_scheduler
    import box_pkg::*;
#(
    parameter int          N_BOX          = 4,
    parameter int          N_REQ          = 2,
    parameter logic [11:0] H_ACT          = 12'd1280,
    parameter logic [11:0] V_ACT          = 12'd720,
    parameter int          TIMEOUT_FRAMES = 8,
    localparam int         XW             = $clog2(H_ACT),
    localparam int         YW             = $clog2(V_ACT),
    localparam int         SW             = $clog2(N_BOX)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                vsync,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ-1:0]    req_clear,
    input  logic [N_REQ*SW-1:0] req_slot,
    input  logic [N_REQ*XW-1:0] req_start_x,
    input  logic [N_REQ*XW-1:0] req_end_x,
    input  logic [N_REQ*YW-1:0] req_start_y,
    input  logic [N_REQ*YW-1:0] req_end_y,
    input  logic [N_REQ*24-1:0] req_color,
    output logic [N_BOX*XW-1:0] start_xs,
    output logic [N_BOX*XW-1:0] end_xs,
    output logic [N_BOX*YW-1:0] start_ys,
    output logic [N_BOX*YW-1:0] end_ys,
    output logic [N_BOX*24-1:0] colors,
    output logic                box_en
);
    logic vsync_q;
    logic fs;
    assign fs = vsync && !vsync_q;

    // Handshake: a write is accepted in a cycle where req_valid[i] && req_ready[i];
    // req_ready is one-hot or zero, is zero in the frame-start cycle and in reset.
    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .req   (req_valid),
        .stall (fs || !rstn),
        .gnt   (req_ready)
    );

    box_t             sh_q [N_BOX];
    box_t             sh_d [N_BOX];
    box_t             live_q [N_BOX];
    box_t             live_d [N_BOX];
    logic [AGE_W-1:0] age_q [N_BOX];
    logic [AGE_W-1:0] age_d [N_BOX];
    logic [N_BOX-1:0] valid_q, valid_d;
    logic [N_BOX-1:0] fresh_q, fresh_d;
    logic [N_BOX-1:0] live_valid_q, live_valid_d;

    logic          wr_en;
    logic          wr_clear;
    logic [SW-1:0] wr_slot;
    box_t          wr_box;

    always_comb begin
        sh_d         = sh_q;
        live_d       = live_q;
        age_d        = age_q;
        valid_d      = valid_q;
        fresh_d      = fresh_q;
        live_valid_d = live_valid_q;
        wr_en        = |req_ready;
        wr_clear     = 1'b0;
        wr_slot      = '0;
        wr_box       = '0;

        for (int r = 0; r < N_REQ; r++) begin
            if (req_ready[r]) begin
                wr_clear     = req_clear[r];
                wr_slot      = req_slot[r*SW +: SW];
                wr_box.x0    = CW'(req_start_x[r*XW +: XW]);
                wr_box.x1    = CW'(req_end_x[r*XW +: XW]);
                wr_box.y0    = CW'(req_start_y[r*YW +: YW]);
                wr_box.y1    = CW'(req_end_y[r*YW +: YW]);
                wr_box.color = req_color[r*24 +: 24];
            end
        end

        if (wr_en && (int'(wr_slot) < N_BOX)) begin
            if (wr_clear) begin
                sh_d[wr_slot]    = '0;
                valid_d[wr_slot] = 1'b0;
                fresh_d[wr_slot] = 1'b0;
                age_d[wr_slot]   = '0;
            end else begin
                sh_d[wr_slot]    = box_sanitize(wr_box, H_ACT - 12'd1, V_ACT - 12'd1);
                valid_d[wr_slot] = 1'b1;
                fresh_d[wr_slot] = 1'b1;
            end
        end

        // Grants are stalled during fs, so the write path above is idle here.
        if (fs) begin
            for (int s = 0; s < N_BOX; s++) begin
                if (fresh_q[s]) begin
                    age_d[s] = '0;
                end else if (valid_q[s] && (age_q[s] != '1)) begin
                    age_d[s] = age_q[s] + 1'b1;
                end
                if (valid_q[s] && !fresh_q[s] && (age_d[s] == AGE_W'(TIMEOUT_FRAMES))) begin
                    sh_d[s]    = '0;
                    valid_d[s] = 1'b0;
                    age_d[s]   = '0;
                end
            end
            fresh_d      = '0;
            live_d       = sh_d;
            live_valid_d = valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vsync_q      <= 1'b0;
            valid_q      <= '0;
            fresh_q      <= '0;
            live_valid_q <= '0;
            for (int s = 0; s < N_BOX; s++) begin
                sh_q[s]   <= '0;
                live_q[s] <= '0;
                age_q[s]  <= '0;
            end
        end else begin
            vsync_q      <= vsync;
            valid_q      <= valid_d;
            fresh_q      <= fresh_d;
            live_valid_q <= live_valid_d;
            sh_q         <= sh_d;
            live_q       <= live_d;
            age_q        <= age_d;
        end
    end

    always_comb begin
        start_xs = '0;
        end_xs   = '0;
        start_ys = '0;
        end_ys   = '0;
        colors   = '0;
        for (int s = 0; s < N_BOX; s++) begin
            start_xs[s*XW +: XW] = live_q[s].x0[XW-1:0];
            end_xs[s*XW +: XW]   = live_q[s].x1[XW-1:0];
            start_ys[s*YW +: YW] = live_q[s].y0[YW-1:0];
            end_ys[s*YW +: YW]   = live_q[s].y1[YW-1:0];
            colors[s*24 +: 24]   = live_q[s].color;
        end
    end

    assign box_en = |live_valid_q;

endmodule

// File: doc/box_scheduler.md
# box_scheduler

Frame-synchronous box table that feeds the box overlay stage. Up to N_REQ producers (detectors, trackers, UI) write box entries through valid/ready ports. A round-robin arbiter serialises the writes into a shadow table. The shadow table is committed to the live table only at frame start, so the overlay never shows a torn box mid-frame. Stale slots age out after TIMEOUT_FRAMES frames without a refresh. The live table drives the overlay stage's start_xs/start_ys/end_xs/end_ys/colors buses directly.

## Interface
- N_BOX, 4, number of box slots; must be ≥2
- N_REQ, 2, number of requester ports; must be ≥1
- H_ACT, 12'd1280, active width; XW = $clog2(H_ACT)
- V_ACT, 12'd720, active height; YW = $clog2(V_ACT)
- TIMEOUT_FRAMES, 8, commits without refresh before a slot is cleared; must be 1..255
- SW (localparam), $clog2(N_BOX)
- clk  in  1  pixel clock; the single clock domain
- rstn  in  1  reset; synchronous, active-low
- vsync  in  1  vsync from the unpacked pixel stream, active high
- req_valid  in  N_REQ  per-requester write request
- req_ready  out  N_REQ  per-requester grant; the write is accepted when valid&&ready
- req_clear  in  N_REQ  1 = invalidate the slot; coordinates and colour are ignored
- req_slot  in  N_REQ*SW  target slot
- req_start_x / req_end_x  in  N_REQ*XW  box x bounds
- req_start_y / req_end_y  in  N_REQ*YW  box y bounds
- req_color  in  N_REQ*24  colour as {r,g,b}
- start_xs, end_xs  out  N_BOX*XW  live table; slot i occupies [(i+1)*XW-1:i*XW]
- start_ys, end_ys  out  N_BOX*YW  live table, packed the same way
- colors  out  N_BOX*24  live colours; slot i occupies [(i+1)*24-1:i*24]
- box_en  out  1  OR of the live valid bits

## Operation
- Frame start (fs) = vsync && !vsync_d, where vsync_d is vsync registered once.
- Arbitration:
  - Round-robin pointer rr ∈ [0,N_REQ).
  - Grant goes to the first requester with valid set, searching from rr upward and wrapping.
  - req_ready is one-hot or zero.
  - After an accepted write, rr becomes the winner's index + 1, modulo N_REQ.
  - During the fs cycle every req_ready is 0 (commit stall).
  - req_ready may depend on req_valid, but requesters must not make req_valid depend on req_ready.
- Shadow write on an accepted request:
  - req_clear=1: the shadow slot's coordinates and colour become 0 and its valid bit is cleared.
  - req_clear=0, sanitising steps:
    - Clamp every x > H_ACT-1 to H_ACT-1 and every y > V_ACT-1 to V_ACT-1.
    - If start_x > end_x after clamping, swap them; do the same for y.
    - Store the result and set the slot's valid bit and `fresh` bit.
- Commit in the fs cycle; all effects take place at the clock edge ending that cycle:
  - Per slot, if fresh=1: age ← 0.
  - Else if valid=1: age ← age+1, saturating.
  - If the new age equals TIMEOUT_FRAMES, clear the shadow slot (zero it, valid ← 0).
  - Copy the post-aging shadow into the live outputs.
  - Clear every fresh bit.
  - Aging only acts on slots with valid=1.
- Invalid slots always present all-zero coordinates, so the overlay stage sees them as inactive.
- A valid box that lies entirely at 0 is indistinguishable from an invalid one; requesters must not use coordinate 0 for a real box.
- Two requesters targeting the same slot in consecutive cycles: the later write wins.

## Timing
- Reset (rstn=0 at a clk edge): all outputs 0, box_en 0, req_ready 0, shadow zeroed, valid/fresh/age 0, rr 0, vsync_d 0.
- Reset mid-frame discards every pending and live box.
- Write latency: a write accepted in cycle t ≤ the next fs cycle appears on the outputs at the edge ending that fs cycle.
- Throughput: one write per cycle, except zero writes in each fs cycle.
- Outputs are registered and change only at the end of an fs cycle or on reset.
- vsync held high does not re-commit. Each rising edge commits exactly once.

## Structure
- Package box_pkg holds:
  - typedef box_t {x0,y0,x1,y1,color[23:0]} parameterised by H_ACT/V_ACT.
  - Localparam AGE_W = 8.
  - Sanitising function box_sanitize(box_t) → box_t covering clamp and swap.
- Sub-module rr_arbiter #(N) (clk, rstn, req, stall, gnt): owns rr and the one-hot grant. Everything else lives inline in box_scheduler.

## Test plan
- Reset, then a single write: req0 writes slot 1 {10,20,100,200,FF0000}; outputs unchanged until fs; after the fs edge, slot 1 fields match and box_en=1.
- Contention: req0 and req1 both valid for 4 cycles; grants must alternate 0,1,0,1, with rr starting at 0.
- Sanitising: write start_x=1500, end_x=50, y=700/30; after commit the slot reads x 50/1279, y 30/700.
- Aging: one write, then TIMEOUT_FRAMES=8 frames with no refresh; the slot stays valid through the 7th commit and is zero after the 8th, with box_en=0. Refreshing every 7th frame keeps it valid.
- Stall and edge: hold req_valid while vsync rises; req_ready is 0 only in the fs cycle. A vsync held high for 3 cycles commits once.
- Mid-frame reset with 3 live boxes and 1 pending write: all outputs are 0 the next cycle, and the next fs commits nothing.
